// File: rtl/data_mem_controller_if.sv
// Bus bundles for the data-memory arbiter: core-facing and memory-facing sides.

interface consumer_mem_if #(
    parameter int unsigned NUM_CONSUMERS = 4,
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 8
);
    logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CONSUMERS-1:0]           consumer_write_valid;
    logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]           consumer_write_ready;

    // Cores issue requests
    modport master (
        output consumer_read_valid, consumer_read_address,
        output consumer_write_valid, consumer_write_address, consumer_write_data,
        input  consumer_read_ready, consumer_read_data, consumer_write_ready
    );

    // Controller serves requests
    modport slave (
        input  consumer_read_valid, consumer_read_address,
        input  consumer_write_valid, consumer_write_address, consumer_write_data,
        output consumer_read_ready, consumer_read_data, consumer_write_ready
    );
endinterface

interface ext_mem_if #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned DATA_BITS = 8
);
    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;
    logic                 mem_write_valid;
    logic [ADDR_BITS-1:0] mem_write_address;
    logic [DATA_BITS-1:0] mem_write_data;
    logic                 mem_write_ready;

    // Controller drives the memory
    modport master (
        output mem_read_valid, mem_read_address,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_read_ready, mem_read_data, mem_write_ready
    );

    // External memory answers
    modport slave (
        input  mem_read_valid, mem_read_address,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_read_ready, mem_read_data, mem_write_ready
    );
endinterface

// File: rtl/data_mem_controller.sv
// Round-robin arbiter putting many cores' data-memory reads/writes onto one
// shared memory port, one transaction in flight at a time.

module data_mem_controller #(
    parameter int unsigned NUM_CONSUMERS = 4,
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 8
) (
    input  logic         clk,
    input  logic         reset,
    consumer_mem_if.slave cons,
    ext_mem_if.master     mem,
    output logic         busy
);
    localparam int unsigned ID_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam int unsigned NC   = NUM_CONSUMERS;

    typedef enum logic [1:0] {IDLE, READ_WAITING, WRITE_WAITING, RELAYING} state_t;

    state_t                  state_q, state_d;
    logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]         grant_id_q, grant_id_d;
    logic                    grant_is_write_q, grant_is_write_d;
    logic                    mem_read_valid_q, mem_read_valid_d;
    logic [ADDR_BITS-1:0]    mem_read_address_q, mem_read_address_d;
    logic                    mem_write_valid_q, mem_write_valid_d;
    logic [ADDR_BITS-1:0]    mem_write_address_q, mem_write_address_d;
    logic [DATA_BITS-1:0]    mem_write_data_q, mem_write_data_d;
    logic [NC-1:0]           read_ready_q, read_ready_d;
    logic [NC-1:0]           write_ready_q, write_ready_d;
    logic [NC*DATA_BITS-1:0] read_data_q, read_data_d;
    logic                    busy_q, busy_d;

    logic                    sel_found;
    logic [ID_W-1:0]         sel_id;
    logic [ID_W-1:0]         cand;
    logic                    sel_read_valid;
    logic [ADDR_BITS-1:0]    sel_read_addr;
    logic [ADDR_BITS-1:0]    sel_write_addr;
    logic [DATA_BITS-1:0]    sel_write_data;
    logic                    grant_read_valid;
    logic                    grant_write_valid;

    // Round-robin search: first requesting core at or after rr_ptr, wrapping
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NC; k++) begin
            cand = ID_W'((32'(rr_ptr_q) + k) % NC);
            if (!sel_found && (cons.consumer_read_valid[cand] || cons.consumer_write_valid[cand])) begin
                sel_found = 1'b1;
                sel_id    = cand;
            end
        end
    end

    // Per-core request muxes for the candidate being granted and the core holding the grant
    always_comb begin
        sel_read_valid    = 1'b0;
        sel_read_addr     = '0;
        sel_write_addr    = '0;
        sel_write_data    = '0;
        grant_read_valid  = 1'b0;
        grant_write_valid = 1'b0;
        for (int unsigned i = 0; i < NC; i++) begin
            if (ID_W'(i) == sel_id) begin
                sel_read_valid = cons.consumer_read_valid[i];
                sel_read_addr  = cons.consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
                sel_write_addr = cons.consumer_write_address[i*ADDR_BITS +: ADDR_BITS];
                sel_write_data = cons.consumer_write_data[i*DATA_BITS +: DATA_BITS];
            end
            if (ID_W'(i) == grant_id_q) begin
                grant_read_valid  = cons.consumer_read_valid[i];
                grant_write_valid = cons.consumer_write_valid[i];
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d             = state_q;
        rr_ptr_d            = rr_ptr_q;
        grant_id_d          = grant_id_q;
        grant_is_write_d    = grant_is_write_q;
        mem_read_valid_d    = mem_read_valid_q;
        mem_read_address_d  = mem_read_address_q;
        mem_write_valid_d   = mem_write_valid_q;
        mem_write_address_d = mem_write_address_q;
        mem_write_data_d    = mem_write_data_q;
        read_data_d         = read_data_q;
        read_ready_d        = '0;
        write_ready_d       = '0;

        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    grant_id_d = sel_id;
                    // A core with both requests pending gets its read first
                    if (sel_read_valid) begin
                        grant_is_write_d   = 1'b0;
                        mem_read_valid_d   = 1'b1;
                        mem_read_address_d = sel_read_addr;
                        state_d            = READ_WAITING;
                    end else begin
                        grant_is_write_d    = 1'b1;
                        mem_write_valid_d   = 1'b1;
                        mem_write_address_d = sel_write_addr;
                        mem_write_data_d    = sel_write_data;
                        state_d             = WRITE_WAITING;
                    end
                end
            end
            READ_WAITING: begin
                if (mem.mem_read_ready) begin
                    mem_read_valid_d = 1'b0;
                    for (int unsigned i = 0; i < NC; i++) begin
                        if (ID_W'(i) == grant_id_q) begin
                            read_data_d[i*DATA_BITS +: DATA_BITS] = mem.mem_read_data;
                            read_ready_d[i]                       = 1'b1;
                        end
                    end
                    state_d = RELAYING;
                end
            end
            WRITE_WAITING: begin
                if (mem.mem_write_ready) begin
                    mem_write_valid_d = 1'b0;
                    for (int unsigned i = 0; i < NC; i++) begin
                        if (ID_W'(i) == grant_id_q) begin
                            write_ready_d[i] = 1'b1;
                        end
                    end
                    state_d = RELAYING;
                end
            end
            RELAYING: begin
                // Only the served direction releases the grant; the other may stay pending
                if (grant_is_write_q ? !grant_write_valid : !grant_read_valid) begin
                    rr_ptr_d = (grant_id_q == ID_W'(NC - 1)) ? '0 : grant_id_q + ID_W'(1);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q             <= IDLE;
            rr_ptr_q            <= '0;
            grant_id_q          <= '0;
            grant_is_write_q    <= 1'b0;
            mem_read_valid_q    <= 1'b0;
            mem_read_address_q  <= '0;
            mem_write_valid_q   <= 1'b0;
            mem_write_address_q <= '0;
            mem_write_data_q    <= '0;
            read_ready_q        <= '0;
            write_ready_q       <= '0;
            read_data_q         <= '0;
            busy_q              <= 1'b0;
        end else begin
            state_q             <= state_d;
            rr_ptr_q            <= rr_ptr_d;
            grant_id_q          <= grant_id_d;
            grant_is_write_q    <= grant_is_write_d;
            mem_read_valid_q    <= mem_read_valid_d;
            mem_read_address_q  <= mem_read_address_d;
            mem_write_valid_q   <= mem_write_valid_d;
            mem_write_address_q <= mem_write_address_d;
            mem_write_data_q    <= mem_write_data_d;
            read_ready_q        <= read_ready_d;
            write_ready_q       <= write_ready_d;
            read_data_q         <= read_data_d;
            busy_q              <= busy_d;
        end
    end

    assign cons.consumer_read_ready  = read_ready_q;
    assign cons.consumer_read_data   = read_data_q;
    assign cons.consumer_write_ready = write_ready_q;
    assign mem.mem_read_valid        = mem_read_valid_q;
    assign mem.mem_read_address      = mem_read_address_q;
    assign mem.mem_write_valid       = mem_write_valid_q;
    assign mem.mem_write_address     = mem_write_address_q;
    assign mem.mem_write_data        = mem_write_data_q;
    assign busy                      = busy_q;

endmodule

// File: tb/tb_data_mem_controller.sv
// Directed bench for data_mem_controller with a latency-configurable memory
// model and an in-order transaction scoreboard.

module tb_data_mem_controller;
    localparam int unsigned NC = 4;
    localparam int unsigned AB = 8;
    localparam int unsigned DB = 8;

    typedef struct packed {
        logic       wr;
        logic [1:0] core;
        logic [7:0] addr;
        logic [7:0] data;
    } txn_t;

    logic clk;
    logic rst_n;
    logic busy;

    consumer_mem_if #(.NUM_CONSUMERS(NC), .ADDR_BITS(AB), .DATA_BITS(DB)) cons();
    ext_mem_if      #(.ADDR_BITS(AB), .DATA_BITS(DB))                     mem();

    data_mem_controller #(.NUM_CONSUMERS(NC), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
        .clk   (clk),
        .reset (rst_n),
        .cons  (cons.slave),
        .mem   (mem.master),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    txn_t       exp_q[$];
    txn_t       obs_q[$];
    int         n_pass  = 0;
    int         n_total = 0;
    logic [7:0] mem_arr [256];
    int         rd_lat = 1;
    int         wr_lat = 1;
    int         rd_cnt = 0;
    int         wr_cnt = 0;
    logic       spur_rd = 1'b0;
    int         rd_pulses [NC];
    int         wr_pulses [NC];
    logic       both_seen;
    logic       unstable;
    int         wv_cycles;
    logic [7:0] hold_addr;
    logic [7:0] hold_data;

    // Memory model: answers each request after a programmable number of cycles
    always @(posedge clk) begin
        mem.mem_read_ready  <= 1'b0;
        mem.mem_write_ready <= 1'b0;
        if (!rst_n) begin
            rd_cnt = 0;
            wr_cnt = 0;
            mem.mem_read_data <= '0;
        end else begin
            if (spur_rd) begin
                mem.mem_read_ready <= 1'b1;
                mem.mem_read_data  <= 8'hEE;
            end
            if (mem.mem_read_valid && !mem.mem_read_ready) begin
                rd_cnt++;
                if (rd_cnt >= rd_lat) begin
                    mem.mem_read_ready <= 1'b1;
                    mem.mem_read_data  <= mem_arr[mem.mem_read_address];
                    rd_cnt = 0;
                end
            end
            if (mem.mem_write_valid && !mem.mem_write_ready) begin
                wr_cnt++;
                if (wr_cnt >= wr_lat) begin
                    mem.mem_write_ready <= 1'b1;
                    wr_cnt = 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    task automatic push_exp(input logic wr, input logic [1:0] core, input logic [7:0] a, input logic [7:0] d);
        txn_t t;
        t.wr   = wr;
        t.core = core;
        t.addr = a;
        t.data = d;
        exp_q.push_back(t);
    endtask

    task automatic rd_req(input int i, input logic [7:0] a);
        cons.consumer_read_valid[i]          = 1'b1;
        cons.consumer_read_address[i*AB +: AB] = a;
    endtask

    task automatic wr_req(input int i, input logic [7:0] a, input logic [7:0] d);
        cons.consumer_write_valid[i]            = 1'b1;
        cons.consumer_write_address[i*AB +: AB] = a;
        cons.consumer_write_data[i*DB +: DB]    = d;
    endtask

    task automatic clear_stats();
        for (int i = 0; i < NC; i++) begin
            rd_pulses[i] = 0;
            wr_pulses[i] = 0;
        end
        both_seen = 1'b0;
        unstable  = 1'b0;
        wv_cycles = 0;
    endtask

    task automatic handle_done(input int i, input logic wr);
        txn_t e;
        txn_t o;
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk("done_core", 32'(i), 32'(e.core));
        chk("done_kind", 32'(wr), 32'(e.wr));
        chk("mem_hs_seen", 32'(obs_q.size() != 0), 32'd1);
        if (obs_q.size() == 0) return;
        o = obs_q.pop_front();
        chk("mem_kind", 32'(o.wr), 32'(e.wr));
        chk("mem_addr", 32'(o.addr), 32'(e.addr));
        if (wr) chk("mem_wdata", 32'(o.data), 32'(e.data));
        else    chk("rd_data", 32'(cons.consumer_read_data[i*DB +: DB]), 32'(e.data));
    endtask

    // Runs cores and monitors until the scoreboard drains and the controller idles
    task automatic service(input int budget);
        int   cyc = 0;
        txn_t o;
        while ((exp_q.size() != 0 || busy === 1'b1) && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (mem.mem_read_valid && mem.mem_write_valid) both_seen = 1'b1;
            if (mem.mem_write_valid) begin
                wv_cycles++;
                if (mem.mem_write_address !== hold_addr || mem.mem_write_data !== hold_data) unstable = 1'b1;
            end
            if (mem.mem_read_valid && mem.mem_read_ready) begin
                o.wr = 1'b0; o.core = '0; o.addr = mem.mem_read_address; o.data = mem.mem_read_data;
                obs_q.push_back(o);
            end
            if (mem.mem_write_valid && mem.mem_write_ready) begin
                o.wr = 1'b1; o.core = '0; o.addr = mem.mem_write_address; o.data = mem.mem_write_data;
                obs_q.push_back(o);
            end
            for (int i = 0; i < NC; i++) begin
                if (cons.consumer_read_ready[i]) begin
                    rd_pulses[i]++;
                    handle_done(i, 1'b0);
                    cons.consumer_read_valid[i] = 1'b0;
                end
                if (cons.consumer_write_ready[i]) begin
                    wr_pulses[i]++;
                    handle_done(i, 1'b1);
                    cons.consumer_write_valid[i] = 1'b0;
                end
            end
        end
        chk("svc_in_budget", 32'(cyc < budget), 32'd1);
    endtask

    initial begin
        int         other;
        logic       saw;
        logic [NC-1:0] acc;
        logic [31:0] snap;

        rst_n                       = 1'b0;
        cons.consumer_read_valid    = '0;
        cons.consumer_read_address  = '0;
        cons.consumer_write_valid   = '0;
        cons.consumer_write_address = '0;
        cons.consumer_write_data    = '0;
        for (int a = 0; a < 256; a++) mem_arr[a] = 8'(a ^ 8'h5C);
        hold_addr = '0;
        hold_data = '0;
        clear_stats();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_rv", 32'(mem.mem_read_valid), 32'd0);
        chk("rst_mem_wv", 32'(mem.mem_write_valid), 32'd0);
        chk("rst_rd_ready", 32'(cons.consumer_read_ready), 32'd0);
        chk("rst_rd_data", cons.consumer_read_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single read from core 2, 2-cycle memory
        clear_stats();
        rd_lat = 2;
        mem_arr[8'h3C] = 8'hA5;
        push_exp(1'b0, 2'd2, 8'h3C, 8'hA5);
        rd_req(2, 8'h3C);
        service(100);
        chk("single_pulses_c2", 32'(rd_pulses[2]), 32'd1);
        other = rd_pulses[0] + rd_pulses[1] + rd_pulses[3] + wr_pulses[0] + wr_pulses[1] + wr_pulses[2] + wr_pulses[3];
        chk("single_other_pulses", 32'(other), 32'd0);
        chk("single_slice", 32'(cons.consumer_read_data[23:16]), 32'hA5);

        // All cores read with rr_ptr at 3: order 3,0,1,2
        rd_lat = 1;
        @(negedge clk);
        for (int i = 0; i < NC; i++) mem_arr[8'h40 + 8'(i)] = 8'h90 + 8'(i);
        for (int i = 0; i < NC; i++) rd_req(i, 8'h40 + 8'(i));
        push_exp(1'b0, 2'd3, 8'h43, 8'h93);
        push_exp(1'b0, 2'd0, 8'h40, 8'h90);
        push_exp(1'b0, 2'd1, 8'h41, 8'h91);
        push_exp(1'b0, 2'd2, 8'h42, 8'h92);
        service(200);

        // Core 3 alone moves rr_ptr to 0
        @(negedge clk);
        mem_arr[8'h4F] = 8'h5A;
        rd_req(3, 8'h4F);
        push_exp(1'b0, 2'd3, 8'h4F, 8'h5A);
        service(100);

        // All cores read with rr_ptr at 0: order 0,1,2,3
        @(negedge clk);
        for (int i = 0; i < NC; i++) mem_arr[8'h60 + 8'(i)] = 8'hB0 + 8'(i);
        for (int i = 0; i < NC; i++) rd_req(i, 8'h60 + 8'(i));
        for (int i = 0; i < NC; i++) push_exp(1'b0, 2'(i), 8'h60 + 8'(i), 8'hB0 + 8'(i));
        service(200);

        // Read before write on core 1, with cores 0 and 2 also pending
        clear_stats();
        hold_addr = 8'h20;
        hold_data = 8'h77;
        @(negedge clk);
        mem_arr[8'h11] = 8'hC1;
        mem_arr[8'h10] = 8'hC0;
        mem_arr[8'h12] = 8'hC2;
        rd_req(0, 8'h11);
        rd_req(1, 8'h10);
        wr_req(1, 8'h20, 8'h77);
        rd_req(2, 8'h12);
        push_exp(1'b0, 2'd0, 8'h11, 8'hC1);
        push_exp(1'b0, 2'd1, 8'h10, 8'hC0);
        push_exp(1'b0, 2'd2, 8'h12, 8'hC2);
        push_exp(1'b1, 2'd1, 8'h20, 8'h77);
        service(300);
        chk("rbw_never_both_valid", 32'(both_seen), 32'd0);
        chk("rbw_wr_pulse_c1", 32'(wr_pulses[1]), 32'd1);

        // Back-pressure: write from core 0 held 10 cycles by memory
        clear_stats();
        wr_lat    = 10;
        hold_addr = 8'h33;
        hold_data = 8'h5E;
        @(negedge clk);
        wr_req(0, 8'h33, 8'h5E);
        push_exp(1'b1, 2'd0, 8'h33, 8'h5E);
        service(200);
        chk("bp_stable", 32'(unstable), 32'd0);
        chk("bp_valid_held", 32'(wv_cycles >= 10), 32'd1);
        chk("bp_wr_pulse_c0", 32'(wr_pulses[0]), 32'd1);

        // Reset during WRITE_WAITING
        wr_lat = 20;
        @(negedge clk);
        wr_req(2, 8'h55, 8'h66);
        saw = 1'b0;
        for (int c = 0; c < 10 && !saw; c++) begin
            @(negedge clk);
            if (mem.mem_write_valid) saw = 1'b1;
        end
        chk("mid_rst_wv_seen", 32'(saw), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wv", 32'(mem.mem_write_valid), 32'd0);
        chk("mid_rst_waddr", 32'(mem.mem_write_address), 32'd0);
        chk("mid_rst_wdata", 32'(mem.mem_write_data), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rd_data", cons.consumer_read_data, 32'd0);
        cons.consumer_write_valid = '0;
        acc = '0;
        repeat (3) begin
            @(negedge clk);
            acc = acc | cons.consumer_write_ready | cons.consumer_read_ready;
        end
        rst_n  = 1'b1;
        wr_lat = 1;
        repeat (3) begin
            @(negedge clk);
            acc = acc | cons.consumer_write_ready | cons.consumer_read_ready;
        end
        chk("mid_rst_no_pulse", 32'(acc), 32'd0);

        // After reset rr_ptr is 0: cores 0 and 3 served 0 then 3
        mem_arr[8'h70] = 8'hD0;
        mem_arr[8'h73] = 8'hD3;
        rd_req(3, 8'h73);
        rd_req(0, 8'h70);
        push_exp(1'b0, 2'd0, 8'h70, 8'hD0);
        push_exp(1'b0, 2'd3, 8'h73, 8'hD3);
        service(100);

        // Unexpected memory ready while idle is ignored
        @(negedge clk);
        snap   = cons.consumer_read_data;
        spur_rd = 1'b1;
        @(negedge clk);
        spur_rd = 1'b0;
        acc = '0;
        repeat (3) begin
            @(negedge clk);
            acc = acc | cons.consumer_read_ready;
        end
        chk("spur_no_pulse", 32'(acc), 32'd0);
        chk("spur_idle", 32'(busy), 32'd0);
        chk("spur_data_kept", cons.consumer_read_data, snap);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_mem_controller.md
# data_mem_controller

Arbitrates the data-memory read and write requests of `NUM_CONSUMERS` cores onto a single shared data-memory port. Each core keeps its existing valid/ready data-memory interface (`data_mem_read_*`, `data_mem_write_*`) and sees the controller as its memory. The controller uses round-robin arbitration, keeps one transaction in flight, and returns read data to the granted core. It sits between the core array and the external data memory.

## Interface
- `NUM_CONSUMERS`, 4: number of cores attached; any value ≥ 2, need not be a power of 2
- `ADDR_BITS`, 8: data-memory address width
- `DATA_BITS`, 8: data-memory data width
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `consumer_read_valid`  in  NUM_CONSUMERS  per-core read request
- `consumer_read_address`  in  NUM_CONSUMERS*ADDR_BITS  per-core read address; core i occupies slice [i*ADDR_BITS +: ADDR_BITS]
- `consumer_read_ready`  out  NUM_CONSUMERS  per-core read completion, one-cycle pulse
- `consumer_read_data`  out  NUM_CONSUMERS*DATA_BITS  per-core read data; valid while the matching ready bit is high
- `consumer_write_valid`  in  NUM_CONSUMERS  per-core write request
- `consumer_write_address`  in  NUM_CONSUMERS*ADDR_BITS  per-core write address
- `consumer_write_data`  in  NUM_CONSUMERS*DATA_BITS  per-core write data
- `consumer_write_ready`  out  NUM_CONSUMERS  per-core write completion, one-cycle pulse
- `mem_read_valid`  out  1  memory read request
- `mem_read_address`  out  ADDR_BITS  memory read address
- `mem_read_ready`  in  1  memory read done, one-cycle pulse; `mem_read_data` is valid while it is high
- `mem_read_data`  in  DATA_BITS  memory read data
- `mem_write_valid`  out  1  memory write request
- `mem_write_address`  out  ADDR_BITS  memory write address
- `mem_write_data`  out  DATA_BITS  memory write data
- `mem_write_ready`  in  1  memory write done, one-cycle pulse
- `busy`  out  1  high whenever the state is not IDLE

## Operation
- States are IDLE, READ_WAITING, WRITE_WAITING and RELAYING.
- **Candidates:** in IDLE, core i is a candidate if its read valid or its write valid is high.
- **Selection:** the controller scans candidates starting at `rr_ptr`, wrapping modulo NUM_CONSUMERS, and picks the first one found.
- **Read before write:** if the selected core has both read and write valid high, the read is served. The write is served on a later grant.
- **On a grant, registered:**
  - `grant_id` and `grant_is_write` are captured.
  - The matching mem address (and mem data, for a write) is captured.
  - The matching mem valid is set.
  - The state goes to READ_WAITING or WRITE_WAITING.
- **READ_WAITING:** when `mem_read_ready` is sampled high:
  - `mem_read_valid` clears.
  - `mem_read_data` is captured into the core's `consumer_read_data` slice.
  - `consumer_read_ready[grant_id]` goes high for one cycle.
  - The state goes to RELAYING.
- **WRITE_WAITING:** same as READ_WAITING, using the write signals; no data is returned.
- **RELAYING:** holds until the served valid of `grant_id` (read or write, whichever was served) is sampled low. Then:
  - `rr_ptr` ← (`grant_id` + 1) mod NUM_CONSUMERS.
  - The state returns to IDLE.
  - The other valid of the same core is ignored here, so a pending write cannot deadlock the controller.
- **Returned data:** each `consumer_read_data` slice holds its last value until that core's next read completes.
- **Mem outputs:** mem address and mem data are stable for the whole time mem valid is high. Mem read valid and mem write valid are never high together.
- **Protocol violation:** a core that drops valid before its ready pulse has violated protocol. The memory transaction still completes and the ready pulse is still issued.

## Timing
- **Reset (asserted low, asynchronous):**
  - All outputs, all `consumer_*_data` slices and `grant_id` go to 0.
  - The state goes to IDLE and `rr_ptr` goes to 0.
  - Reset during a transaction abandons it: mem valid drops immediately and no ready pulse is issued.
- **Request to memory:** a request sampled at edge e in IDLE drives mem valid high after edge e.
- **Memory to core:** `mem_*_ready` sampled at edge m drives the consumer ready pulse high for the cycle after m, and `busy` stays high.
- **Best-case occupancy:** with a 1-cycle memory and a core that drops valid at its ready pulse, one transfer occupies 4 cycles, edge to edge: grant, mem handshake, ready pulse, release.
- **Unexpected ready:** a mem ready that arrives while its mem valid is low is ignored.

## Test plan
- **Single read:** core 2 reads address 0x3C; the memory returns 0xA5 with a 2-cycle latency.
  - `mem_read_address` = 0x3C; exactly one pulse on `consumer_read_ready[2]`.
  - `consumer_read_data[23:16]` = 0xA5; other ready bits stay 0.
- **Round-robin:** all 4 cores request reads at once; repeat with `rr_ptr` at 3.
  - Grant order is 0, 1, 2, 3.
  - With `rr_ptr` at 3, the order is 3, 0, 1, 2.
- **Read before write:** core 1 raises read (address 0x10) and write (address 0x20, data 0x77) together.
  - The read is served first.
  - After the other pending cores have been served, the write reaches memory with address 0x20 and data 0x77.
  - `mem_read_valid` and `mem_write_valid` are never high together.
- **Back-pressure:** memory holds ready low for 10 cycles during a write from core 0.
  - The mem address, data and valid hold steady for all 10 cycles.
  - `consumer_write_ready[0]` pulses exactly once.
- **Reset mid-transaction:** assert `reset` low in WRITE_WAITING.
  - All outputs go to 0 immediately and no ready pulse follows.
  - After release, a read from core 3 completes normally with `rr_ptr` = 0 behaviour.
